// File: rtl/stepper_pkg.sv
// Shared types for the stepper move scheduler.
package stepper_pkg;

    localparam int DEF_POS_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SETTLE,
        DONE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the search starts just after last_grant.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             en,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                j = (int'(last_grant) + k) % NREQ;
                if (!found && req[j]) begin
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stepper_move_sched.sv
// Round-robin move scheduler producing rate-limited step pulses
// and tracking absolute position for the phase sequencer.
module stepper_move_sched
    import stepper_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int POS_W        = DEF_POS_W,
    parameter int DIV_W        = 19,
    parameter int STEP_DIV     = 2**18,
    parameter int SETTLE_TICKS = 4,
    parameter int IDX_W        = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*POS_W-1:0]   req_target,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    abort,
    output logic                    step_pulse,
    output logic                    step_dir,
    output logic                    motor_en,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        grant_id
);

    localparam int SET_W = $clog2(SETTLE_TICKS + 1);

    sched_state_t            state;
    logic [DIV_W-1:0]        div_cnt;
    logic [SET_W-1:0]        settle_cnt;
    logic signed [POS_W-1:0] target;
    logic signed [POS_W-1:0] pos_next;
    logic signed [POS_W-1:0] sel_target;
    logic signed [POS_W:0]   delta;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic [NREQ-1:0]         arb_grant;
    logic                    abort_pend;
    logic                    abort_eff;
    logic                    tick;
    logic                    accept;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .en         (state == IDLE),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    assign req_ready  = arb_grant;
    assign accept     = |arb_grant;
    assign sel_target = $signed(req_target[arb_idx*POS_W +: POS_W]);
    // Sign-extend both operands so the difference cannot overflow
    assign delta      = {sel_target[POS_W-1], sel_target}
                      - {position[POS_W-1], position};

    assign tick       = (div_cnt == DIV_W'(STEP_DIV - 1));
    assign abort_eff  = abort_pend | abort;
    assign pos_next   = step_dir ? position + POS_W'(1)
                                 : position - POS_W'(1);

    assign step_pulse = (state == RUN) && tick && !abort_eff
                      && (position != target);
    assign motor_en   = (state == RUN) || (state == SETTLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            position   <= '0;
            target     <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            grant_id   <= '0;
            step_dir   <= 1'b0;
            div_cnt    <= '0;
            settle_cnt <= '0;
            abort_pend <= 1'b0;
        end else begin
            if (motor_en && !tick)
                div_cnt <= div_cnt + 1'b1;
            else
                div_cnt <= '0;

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        target     <= sel_target;
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        step_dir   <= !delta[POS_W] && (delta != '0);
                        abort_pend <= 1'b0;
                        settle_cnt <= '0;
                        state      <= (delta == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (abort)
                        abort_pend <= 1'b1;
                    if (tick) begin
                        if (abort_eff) begin
                            target     <= position;
                            abort_pend <= 1'b0;
                            state      <= SETTLE;
                        end else begin
                            position <= pos_next;
                            if (pos_next == target)
                                state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (tick) begin
                        if (settle_cnt == SET_W'(SETTLE_TICKS - 1))
                            state <= DONE;
                        else
                            settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_sched.sv
// Directed bench for stepper_move_sched with STEP_DIV=4, SETTLE_TICKS=2.
module tb_stepper_move_sched;

    localparam int NREQ  = 2;
    localparam int POS_W = 14;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*POS_W-1:0]   req_target;
    logic [NREQ-1:0]         req_ready;
    logic                    abort;
    logic                    step_pulse;
    logic                    step_dir;
    logic                    motor_en;
    logic signed [POS_W-1:0] position;
    logic                    busy;
    logic                    done;
    logic [0:0]              grant_id;

    stepper_move_sched #(
        .NREQ         (NREQ),
        .POS_W        (POS_W),
        .DIV_W        (19),
        .STEP_DIV     (4),
        .SETTLE_TICKS (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (req_ready),
        .abort      (abort),
        .step_pulse (step_pulse),
        .step_dir   (step_dir),
        .motor_en   (motor_en),
        .position   (position),
        .busy       (busy),
        .done       (done),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   pulses[$];
    int   done_q[$];
    int   dir_bad = 0;
    logic exp_dir = 1'b0;
    logic en_seen = 1'b0;

    always @(negedge clk) begin
        if (step_pulse) begin
            pulses.push_back(cyc);
            if (step_dir !== exp_dir) dir_bad++;
        end
        if (done === 1'b1) done_q.push_back(cyc);
        if (motor_en === 1'b1) en_seen = 1'b1;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic stepc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int tgt);
        req_target[i*POS_W +: POS_W] = POS_W'(tgt);
        req_valid[i] = 1'b1;
    endtask

    task automatic clear_log();
        pulses.delete();
        done_q.delete();
        dir_bad = 0;
        en_seen = 1'b0;
    endtask

    task automatic wait_done(input int max, output int dc);
        int got;
        got = 0;
        dc  = -1;
        for (int i = 0; i < max; i++) begin
            stepc();
            if (done === 1'b1) begin
                got = 1;
                dc  = cyc;
                break;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic wait_pulses(input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (pulses.size() >= n) break;
            stepc();
        end
        chk("pulse_wait", pulses.size(), n);
    endtask

    function automatic int pulse_at(input int k);
        return (pulses.size() > k) ? pulses[k] : -1;
    endfunction

    int t;
    int dc;

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_target = '0;
        abort      = 1'b0;
        repeat (3) stepc();
        reset = 1'b0;
        stepc();

        // Reset state
        chk("rst_position", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_motor_en", motor_en, 0);
        chk("rst_done", done, 0);
        chk("rst_step_pulse", step_pulse, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);

        // Move to +3
        clear_log();
        exp_dir = 1'b1;
        set_req(0, 3);
        #1;
        chk("m1_ready", req_ready, 2'b01);
        t = cyc;
        stepc();
        req_valid = '0;
        chk("m1_busy", busy, 1);
        chk("m1_motor_en", motor_en, 1);
        wait_done(60, dc);
        chk("m1_done_cyc", dc - t, 21);
        chk("m1_npulse", pulses.size(), 3);
        chk("m1_pulse0", pulse_at(0) - t, 4);
        chk("m1_pulse1", pulse_at(1) - t, 8);
        chk("m1_pulse2", pulse_at(2) - t, 12);
        chk("m1_position", position, 3);
        chk("m1_dir", dir_bad, 0);
        stepc();
        chk("m1_idle_busy", busy, 0);

        // Move to -2 from requester 1
        clear_log();
        exp_dir = 1'b0;
        set_req(1, -2);
        #1;
        chk("m2_ready", req_ready, 2'b10);
        t = cyc;
        stepc();
        req_valid = '0;
        wait_done(80, dc);
        chk("m2_done_cyc", dc - t, 29);
        chk("m2_npulse", pulses.size(), 5);
        chk("m2_position", position, -2);
        chk("m2_grant_id", grant_id, 1);
        chk("m2_dir", dir_bad, 0);
        stepc();

        // Contention: both held
        clear_log();
        exp_dir = 1'b1;
        set_req(0, 5);
        set_req(1, 0);
        #1;
        chk("m3a_ready", req_ready, 2'b01);
        t = cyc;
        stepc();
        chk("m3a_ready_busy", req_ready, 2'b00);
        chk("m3a_grant_id", grant_id, 0);
        wait_done(100, dc);
        chk("m3a_done_cyc", dc - t, 37);
        chk("m3a_position", position, 5);
        chk("m3a_npulse", pulses.size(), 7);
        chk("m3a_dir", dir_bad, 0);
        stepc();
        clear_log();
        exp_dir = 1'b0;
        chk("m3b_ready", req_ready, 2'b10);
        t = cyc;
        wait_done(80, dc);
        chk("m3b_done_cyc", dc - t, 29);
        chk("m3b_position", position, 0);
        chk("m3b_grant_id", grant_id, 1);
        chk("m3b_npulse", pulses.size(), 5);
        chk("m3b_dir", dir_bad, 0);
        stepc();
        chk("m3c_ready", req_ready, 2'b01);
        req_valid = '0;
        #1;

        // Zero-length move
        clear_log();
        set_req(0, 0);
        #1;
        chk("m4_ready", req_ready, 2'b01);
        t = cyc;
        stepc();
        req_valid = '0;
        chk("m4_done", done, 1);
        chk("m4_busy", busy, 1);
        stepc();
        chk("m4_done_drop", done, 0);
        chk("m4_idle", busy, 0);
        stepc();
        chk("m4_npulse", pulses.size(), 0);
        chk("m4_en_seen", en_seen, 0);
        chk("m4_ndone", done_q.size(), 1);

        // Abort after the 2nd pulse
        clear_log();
        exp_dir = 1'b1;
        set_req(0, 10);
        #1;
        chk("m5_ready", req_ready, 2'b01);
        t = cyc;
        stepc();
        req_valid = '0;
        wait_pulses(2, 40);
        stepc();
        abort = 1'b1;
        stepc();
        abort = 1'b0;
        wait_done(60, dc);
        chk("m5_done_cyc", dc - t, 21);
        chk("m5_npulse", pulses.size(), 2);
        chk("m5_position", position, 2);
        stepc();

        // Reset in mid-move
        clear_log();
        exp_dir = 1'b1;
        set_req(1, 6);
        #1;
        chk("m6_ready", req_ready, 2'b10);
        stepc();
        req_valid = '0;
        wait_pulses(3, 40);
        stepc();
        reset = 1'b1;
        stepc();
        chk("m6_position", position, 0);
        chk("m6_busy", busy, 0);
        chk("m6_motor_en", motor_en, 0);
        chk("m6_step_pulse", step_pulse, 0);
        chk("m6_done", done, 0);
        chk("m6_grant_id", grant_id, 0);
        reset = 1'b0;
        repeat (20) stepc();
        chk("m6_no_done", done_q.size(), 0);
        chk("m6_npulse", pulses.size(), 3);

        // Normal move after reset
        clear_log();
        exp_dir = 1'b1;
        set_req(0, 1);
        #1;
        chk("m7_ready", req_ready, 2'b01);
        t = cyc;
        stepc();
        req_valid = '0;
        wait_done(40, dc);
        chk("m7_done_cyc", dc - t, 13);
        chk("m7_position", position, 1);
        chk("m7_npulse", pulses.size(), 1);
        chk("m7_dir", dir_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
